uart_rx_byte: RTL and testbench
===============================

// Module: uart_rx_byte
// PURPOSE
//  8N1 UART receiver: the receiving end of the SoC uart0 stx line. Deserialises rx_i into bytes.
//  Presents each byte on a one-entry valid/ready holding buffer.
//  Used as the bench-side console sink and as an on-chip RX path.
//  Flags framing errors and overruns.
// PARAMETERS
//  CLKS_PER_BIT  434  wb_clk cycles per bit (50 MHz / 115200); legal range 4..65535
// PORTS
//  wb_clk       in   1  system clock; all logic on rising edge
//  wb_rst       in   1  synchronous active-high reset
//  rx_i         in   1  async serial input, idle high
//  data_o       out  8  received byte, valid while valid_o=1
//  valid_o      out  1  holding buffer full
//  ready_i      in   1  consumer accepts data_o when valid_o & ready_i
//  frame_err_o  out  1  1-cycle pulse: stop bit sampled low
//  overrun_o    out  1  1-cycle pulse: byte completed while buffer full and not drained
//  busy_o       out  1  1 when FSM not IDLE
// BEHAVIOUR
//  Reset (wb_rst=1, any cycle incl. mid-frame):
//   - data_o=0, valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0
//   - FSM->IDLE, counters=0, sync flops=1
//  Sync: rx_s = 2-flop synchroniser of rx_i. Edge-to-FSM latency is 2 cycles.
//  Counters:
//   - cnt is $clog2(CLKS_PER_BIT) bits; counts 0..CLKS_PER_BIT-1 then wraps to 0
//   - bit_cnt is 3 bits
//  FSM:
//   IDLE   - rx_s==0 -> START, cnt=0
//   START  - at cnt==CLKS_PER_BIT/2-1 (integer div): rx_s==0 -> DATA, cnt=0, bit_cnt=0
//          - rx_s==1 -> IDLE (glitch rejected, no flags)
//   DATA   - at cnt==CLKS_PER_BIT-1: shift rx_s into bit bit_cnt (LSB first), bit_cnt++
//          - after bit 7 -> STOP, cnt=0
//   STOP   - at cnt==CLKS_PER_BIT-1:
//            rx_s==1 -> byte complete, IDLE
//            rx_s==0 -> frame_err_o=1 next cycle, byte discarded, WAITHI
//   WAITHI - stay until rx_s==1 (break / stuck-low line), then IDLE
//  Holding buffer (updated in the cycle after stop sample):
//   - accept = valid_o & ready_i clears valid_o unless a new byte loads the same cycle
//   - byte complete & (!valid_o | accept): data_o<=byte, valid_o<=1
//   - byte complete & valid_o & !ready_i: new byte dropped; data_o unchanged; overrun_o pulses 1 cycle
//   - data_o stable while valid_o=1
//  Timing: stop sample to valid_o=1 is 1 cycle. Next start bit may begin the cycle after STOP->IDLE.
//  Back-to-back frames need no gap.
//  frame_err_o and overrun_o never assert together (mutually exclusive by construction).
// TESTING (bench CLKS_PER_BIT=16, ideal-timed stimulus)
//  1. Send 0xA5, ready_i=1 -> valid_o=1 one cycle, data_o=0xA5, no flags; busy_o high exactly during frame.
//  2. rx_i low for 4 cycles then high -> no valid_o, no flags; FSM back to IDLE, busy_o=0.
//  3. Send 0x3C with stop bit 0, hold rx_i low 40 cycles -> frame_err_o 1-cycle pulse, valid_o=0;
//     FSM stays busy until rx_i high; then 0x55 -> data_o=0x55.
//  4. ready_i=0; send 0x11 then 0x22 -> valid_o=1, data_o=0x11; overrun_o pulses once at 2nd byte;
//     raise ready_i -> accepted, valid_o=0.
//  5. Back-to-back 0x00,0xFF,0x81 with zero idle gap, ready_i=1 -> three valid_o pulses, bytes in order.
//  6. Assert wb_rst mid-DATA of 0x77 -> all outputs 0 next cycle; following frame 0x42 received correctly.

Source files
------------

// File: rtl/uart_rx_byte.sv
// ---------------------------------------------------------------------------
// uart_rx_byte
//   8N1 UART receiver. Deserialises the asynchronous rx_i line into bytes and
//   presents each byte through a one-entry valid/ready holding buffer. Flags
//   stop-bit framing errors and bytes lost because the buffer was still full.
//
// Parameters
//   CLKS_PER_BIT  wb_clk cycles per serial bit (legal range 4..65535)
//
// Ports
//   wb_clk       in   system clock, all logic on the rising edge
//   wb_rst       in   synchronous active-high reset
//   rx_i         in   asynchronous serial input, idle high
//   data_o       out  received byte, valid while valid_o=1
//   valid_o      out  holding buffer full
//   ready_i      in   consumer takes data_o when valid_o & ready_i
//   frame_err_o  out  one-cycle pulse: stop bit sampled low
//   overrun_o    out  one-cycle pulse: byte completed while buffer full
//   busy_o       out  receiver state machine not idle
// ---------------------------------------------------------------------------
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       wb_clk,
  input  logic       wb_rst,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  // Start bit is re-checked half a bit in, which also centres every later sample.
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_WAITHI = 3'd4
  } state_t;

  logic             r_sync1;
  logic             r_sync2;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_ferr;
  logic             r_ovr;
  logic             r_busy;

  logic             w_rx_s;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_bit_cnt_nxt;
  logic [7:0]       w_shift_nxt;
  logic             w_done;
  logic             w_ferr;
  logic             w_accept;

  assign w_rx_s   = r_sync2;
  assign w_accept = r_valid & ready_i;

  assign data_o      = r_data;
  assign valid_o     = r_valid;
  assign frame_err_o = r_ferr;
  assign overrun_o   = r_ovr;
  assign busy_o      = r_busy;

  // Two-flop synchroniser for the asynchronous serial line (idles high).
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_i;
      r_sync2 <= r_sync1;
    end
  end

  // Receiver state, bit timing counters and shift register.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= {CNT_W{1'b0}};
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'd0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
    end
  end

  // Next-state logic: bit timing, data sampling, stop-bit verdict.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_done        = 1'b0;
    w_ferr        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = {CNT_W{1'b0}};
        if (!w_rx_s) begin
          w_state_nxt = S_START;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (r_cnt == CNT_HALF) begin
          w_cnt_nxt     = {CNT_W{1'b0}};
          w_bit_cnt_nxt = 3'd0;
          // A line that is high again mid start bit was only a glitch.
          if (!w_rx_s) begin
            w_state_nxt = S_DATA;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt              = {CNT_W{1'b0}};
          w_shift_nxt[r_bit_cnt] = w_rx_s;
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt   = S_STOP;
            w_bit_cnt_nxt = 3'd0;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt = {CNT_W{1'b0}};
          if (w_rx_s) begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            // Byte is discarded; wait for the line to recover before re-arming.
            w_ferr      = 1'b1;
            w_state_nxt = S_WAITHI;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_WAITHI: begin
        w_cnt_nxt = {CNT_W{1'b0}};
        if (w_rx_s) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAITHI;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_cnt_nxt     = {CNT_W{1'b0}};
        w_bit_cnt_nxt = 3'd0;
      end
    endcase
  end

  // One-entry holding buffer plus the error pulses.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_data  <= 8'd0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_ferr;
      r_ovr  <= 1'b0;
      if (w_done && (!r_valid || w_accept)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (w_done) begin
        // Buffer full and not draining: keep the old byte, drop the new one.
        r_ovr <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_byte
//   Directed bench for uart_rx_byte with CLKS_PER_BIT=16. Stimulus tasks drive
//   ideal-timed frames and, from the frame timing arithmetic, predict when the
//   receiver is busy and when bytes / framing errors complete. A per-cycle
//   compare process applies the holding-buffer rules to those predictions and
//   checks every output; literal checks pin the received bytes and pulse counts.
// ---------------------------------------------------------------------------
module tb_uart_rx_byte;

  localparam int CPB  = 16;
  localparam int NCYC = 4096;
  // Cycles from the start-bit launch to the edge that acts on the stop sample:
  // 3 (sync + idle detect) + half bit + 8 data bits + full stop bit period.
  localparam int T_DONE = 3 + CPB / 2 + 9 * CPB;
  localparam int T_FRAME = 10 * CPB;

  logic       wb_clk  = 1'b0;
  logic       wb_rst  = 1'b1;
  logic       rx_i    = 1'b1;
  logic       ready_i = 1'b1;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit         exp_busy [NCYC];
  bit         ev_done  [NCYC];
  bit         ev_ferr  [NCYC];
  logic [7:0] ev_byte  [NCYC];

  logic       m_valid = 1'b0;
  logic [7:0] m_data  = 8'd0;
  logic       m_ferr  = 1'b0;
  logic       m_ovr   = 1'b0;

  logic [7:0] rcv_q [$];
  int valid_cycles = 0;
  int ferr_cnt     = 0;
  int ovr_cnt      = 0;

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .wb_clk      (wb_clk),
    .wb_rst      (wb_rst),
    .rx_i        (rx_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o)
  );

  always #5 wb_clk = ~wb_clk;

  always @(posedge wb_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Compare outputs after edge cyc with the model, then advance the model to
  // the next edge using the inputs that edge will sample.
  always @(negedge wb_clk) begin
    logic acc;
    int   e;
    e = cyc;
    if (e < NCYC - 1) begin
      check("valid_o", valid_o, m_valid);
      check("data_o", data_o, m_data);
      check("frame_err_o", frame_err_o, m_ferr);
      check("overrun_o", overrun_o, m_ovr);
      check("busy_o", busy_o, exp_busy[e]);
      if (valid_o && ready_i) rcv_q.push_back(data_o);
      if (valid_o) valid_cycles++;
      if (frame_err_o) ferr_cnt++;
      if (overrun_o) ovr_cnt++;
      if (wb_rst) begin
        m_valid = 1'b0;
        m_data  = 8'd0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
      end else begin
        acc    = m_valid && ready_i;
        m_ferr = ev_ferr[e + 1];
        m_ovr  = 1'b0;
        if (ev_done[e + 1]) begin
          if (!m_valid || acc) begin
            m_data  = ev_byte[e + 1];
            m_valid = 1'b1;
          end else begin
            m_ovr = 1'b1;
          end
        end else if (acc) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    #(NCYC * 10);
    $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
    $fatal(1);
  end

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) tick();
  endtask

  // Full frame; with stop_bit=0 the line stays low hold_low cycles after the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int hold_low);
    int n;
    int h;
    n = cyc;
    for (int c = n + 3; c <= n + T_DONE - 1; c++) exp_busy[c] = 1'b1;
    if (stop_bit) begin
      ev_done[n + T_DONE] = 1'b1;
      ev_byte[n + T_DONE] = b;
    end else begin
      ev_ferr[n + T_DONE] = 1'b1;
      h = n + T_FRAME + hold_low;
      for (int c = n + T_DONE; c <= h + 2; c++) exp_busy[c] = 1'b1;
    end
    rx_i = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) tick();
    end
    rx_i = stop_bit;
    repeat (CPB) tick();
    if (!stop_bit) begin
      repeat (hold_low) tick();
      rx_i = 1'b1;
    end
  endtask

  task automatic send_glitch(input int low_cycles);
    int n;
    n = cyc;
    for (int c = n + 3; c <= n + 3 + CPB / 2 - 1; c++) exp_busy[c] = 1'b1;
    rx_i = 1'b0;
    repeat (low_cycles) tick();
    rx_i = 1'b1;
  endtask

  // Start a frame, then reset the receiver during its fourth data bit.
  task automatic send_aborted(input logic [7:0] b);
    int n;
    int r;
    n = cyc;
    r = n + 4 * CPB;
    for (int c = n + 3; c <= r; c++) exp_busy[c] = 1'b1;
    rx_i = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 3; i++) begin
      rx_i = b[i];
      repeat (CPB) tick();
    end
    rx_i   = b[3];
    wb_rst = 1'b1;
    rx_i   = 1'b1;
    tick();
    wb_rst = 1'b0;
  endtask

  task automatic expect_rx(input string name, input logic [7:0] exp);
    if (rcv_q.size() == 0) begin
      check(name, 32'h100, {24'd0, exp});
    end else begin
      check(name, {24'd0, rcv_q.pop_front()}, {24'd0, exp});
    end
  endtask

  initial begin
    int vc0;
    int fe0;
    int ov0;
    wb_rst  = 1'b1;
    rx_i    = 1'b1;
    ready_i = 1'b1;
    repeat (3) tick();
    check("reset valid_o", valid_o, 1'b0);
    check("reset data_o", data_o, 8'h00);
    check("reset busy_o", busy_o, 1'b0);
    wb_rst = 1'b0;
    idle(5);

    // 1: single byte, consumer ready.
    rcv_q.delete();
    vc0 = valid_cycles;
    send_frame(8'hA5, 1'b1, 0);
    idle(5);
    check("t1 valid cycles", valid_cycles - vc0, 1);
    check("t1 rx count", rcv_q.size(), 1);
    expect_rx("t1 byte", 8'hA5);

    // 2: short low glitch is rejected.
    rcv_q.delete();
    fe0 = ferr_cnt;
    send_glitch(4);
    idle(20);
    check("t2 busy_o", busy_o, 1'b0);
    check("t2 rx count", rcv_q.size(), 0);
    check("t2 ferr count", ferr_cnt - fe0, 0);

    // 3: framing error with stuck-low line, then recovery.
    rcv_q.delete();
    fe0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 40);
    idle(20);
    check("t3 ferr count", ferr_cnt - fe0, 1);
    check("t3 rx count", rcv_q.size(), 0);
    send_frame(8'h55, 1'b1, 0);
    idle(5);
    expect_rx("t3 byte", 8'h55);

    // 4: overrun while the consumer stalls.
    rcv_q.delete();
    ov0 = ovr_cnt;
    ready_i = 1'b0;
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 0);
    idle(10);
    check("t4 valid_o held", valid_o, 1'b1);
    check("t4 data_o held", data_o, 8'h11);
    check("t4 overrun count", ovr_cnt - ov0, 1);
    ready_i = 1'b1;
    tick();
    check("t4 valid_o drained", valid_o, 1'b0);
    check("t4 rx count", rcv_q.size(), 1);
    expect_rx("t4 byte", 8'h11);
    idle(5);

    // 5: back-to-back frames, no idle gap.
    rcv_q.delete();
    vc0 = valid_cycles;
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    send_frame(8'h81, 1'b1, 0);
    idle(5);
    check("t5 valid cycles", valid_cycles - vc0, 3);
    check("t5 rx count", rcv_q.size(), 3);
    expect_rx("t5 byte0", 8'h00);
    expect_rx("t5 byte1", 8'hFF);
    expect_rx("t5 byte2", 8'h81);

    // 6: reset mid-frame with a full buffer, then a clean frame.
    rcv_q.delete();
    ready_i = 1'b0;
    send_frame(8'h99, 1'b1, 0);
    idle(3);
    check("t6 buffer full", valid_o, 1'b1);
    send_aborted(8'h77);
    check("t6 rst valid_o", valid_o, 1'b0);
    check("t6 rst data_o", data_o, 8'h00);
    check("t6 rst busy_o", busy_o, 1'b0);
    check("t6 rst frame_err_o", frame_err_o, 1'b0);
    check("t6 rst overrun_o", overrun_o, 1'b0);
    ready_i = 1'b1;
    idle(10);
    send_frame(8'h42, 1'b1, 0);
    idle(5);
    check("t6 rx count", rcv_q.size(), 1);
    expect_rx("t6 byte", 8'h42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
